// File: rtl/counter_seq_arbiter.sv
// Round-robin controller sharing one loadable free-running up counter between two requesters.
// Optional RUN watchdog with err abort pulse is enabled by defining CSA_TIMEOUT_EN.
module counter_seq_arbiter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req,
    input  logic [W-1:0] start0,
    input  logic [W-1:0] start1,
    input  logic [W-1:0] stop0,
    input  logic [W-1:0] stop1,
    output logic [1:0]   grant,
    output logic         busy,
    output logic         done,
    output logic         done_id,
    output logic         err,
    output logic         ctr_load,
    output logic [W-1:0] ctr_data,
    input  logic [W-1:0] ctr_count
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e       state_q, state_d;
    logic [W-1:0] st_q, st_d;
    logic [W-1:0] sp_q, sp_d;
    logic         id_q, id_d;
    logic         lp_q, lp_d;
    logic         win;
    logic         match;
    logic         timeout;

    assign match = (ctr_count == sp_q);

`ifdef CSA_TIMEOUT_EN
    localparam logic [W:0] WdLimit = {1'b1, {W{1'b0}}};

    logic [W:0] wd_q, wd_d;
    logic       err_q, err_d;

    // Watchdog counts RUN cycles; hitting 2^W means 2^W+1 cycles without a match.
    assign timeout = (wd_q == WdLimit);

    always_comb begin
        wd_d = wd_q;
        if (state_q == StLoad) begin
            wd_d = '0;
        end else if (state_q == StRun) begin
            wd_d = wd_q + 1'b1;
        end
        err_d = (state_q == StRun) && !match && timeout;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        unique case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            default: win = ~lp_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            st_q    <= '0;
            sp_q    <= '0;
            id_q    <= 1'b0;
            lp_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            sp_q    <= sp_d;
            id_q    <= id_d;
            lp_q    <= lp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        sp_d    = sp_q;
        id_d    = id_q;
        lp_d    = lp_q;
        unique case (state_q)
            StIdle: begin
                if (req != 2'b00) begin
                    id_d    = win;
                    st_d    = win ? start1 : start0;
                    sp_d    = win ? stop1 : stop0;
                    state_d = StLoad;
                end
            end
            StLoad: state_d = StRun;
            StRun: begin
                if (match) begin
                    lp_d    = id_q;
                    state_d = StDone;
                end else if (timeout) begin
                    lp_d    = id_q;
                    state_d = StIdle;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        grant    = 2'b00;
        busy     = 1'b0;
        done     = 1'b0;
        done_id  = 1'b0;
        ctr_load = 1'b0;
        ctr_data = '0;
        unique case (state_q)
            StLoad: begin
                grant[id_q] = 1'b1;
                busy        = 1'b1;
                ctr_load    = 1'b1;
                ctr_data    = st_q;
            end
            StRun: busy = 1'b1;
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                done_id = id_q;
            end
            default: ;
        endcase
`ifdef CSA_TIMEOUT_EN
        err = err_q;
        if (err_q) begin
            done_id = id_q;
        end
`else
        err = 1'b0;
`endif
    end

endmodule

// File: tb/tb_counter_seq_arbiter.sv
// Directed bench for counter_seq_arbiter with a behavioural 4-bit counter attached.
// Covers the CSA_TIMEOUT_EN watchdog when that macro is defined.
module tb_counter_seq_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [3:0] start0, start1, stop0, stop1;
    logic [1:0] grant;
    logic       busy, done, done_id, err, ctr_load;
    logic [3:0] ctr_data, ctr_count;
    logic [3:0] cnt = 4'd0;
    logic       stuck = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ctr_load) cnt <= ctr_data;
        else          cnt <= cnt + 4'd1;
    end
    assign ctr_count = stuck ? 4'd0 : cnt;

    counter_seq_arbiter #(.W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .start0   (start0),
        .start1   (start1),
        .stop0    (stop0),
        .stop1    (stop1),
        .grant    (grant),
        .busy     (busy),
        .done     (done),
        .done_id  (done_id),
        .err      (err),
        .ctr_load (ctr_load),
        .ctr_data (ctr_data),
        .ctr_count(ctr_count)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"}, {7'd0, busy}, 8'd0);
        chk({tag, ".done"}, {7'd0, done}, 8'd0);
        chk({tag, ".grant"}, {6'd0, grant}, 8'd0);
        chk({tag, ".err"}, {7'd0, err}, 8'd0);
        chk({tag, ".ctr_load"}, {7'd0, ctr_load}, 8'd0);
        chk({tag, ".ctr_data"}, {4'd0, ctr_data}, 8'd0);
    endtask

    // One full run: request in IDLE, LOAD, k+1 RUN cycles, DONE, back to IDLE.
    task automatic run(input string tag, input logic [1:0] r, input logic id,
                       input logic [3:0] st, input logic [3:0] sp, input logic drop);
        logic [3:0] k;
        logic [3:0] e;
        req = r;
        step();
        chk({tag, ".grant"}, {6'd0, grant}, id ? 8'd2 : 8'd1);
        chk({tag, ".load"}, {7'd0, ctr_load}, 8'd1);
        chk({tag, ".data"}, {4'd0, ctr_data}, {4'd0, st});
        chk({tag, ".busy_l"}, {7'd0, busy}, 8'd1);
        if (drop) req = 2'b00;
        k = sp - st;
        for (int j = 0; j <= int'(k); j++) begin
            step();
            e = st + 4'(j);
            chk({tag, ".run_cnt"}, {4'd0, ctr_count}, {4'd0, e});
            chk({tag, ".run_busy"}, {7'd0, busy}, 8'd1);
            chk({tag, ".run_done"}, {7'd0, done}, 8'd0);
            chk({tag, ".run_grant"}, {6'd0, grant}, 8'd0);
            chk({tag, ".run_load"}, {7'd0, ctr_load}, 8'd0);
        end
        step();
        chk({tag, ".done"}, {7'd0, done}, 8'd1);
        chk({tag, ".done_id"}, {7'd0, done_id}, {7'd0, id});
        chk({tag, ".busy_d"}, {7'd0, busy}, 8'd1);
        step();
        chk_idle({tag, ".after"});
    endtask

    initial begin
        reset  = 1'b0;
        req    = 2'b00;
        start0 = 4'd0; stop0 = 4'd2;
        start1 = 4'd0; stop1 = 4'd2;
        #12;
        chk_idle("reset");
        chk("reset.done_id", {7'd0, done_id}, 8'd0);
        reset = 1'b1;
        step();
        chk_idle("post_reset");

        // Held 11: tie-break alternates starting with requester 0.
        run("rr0", 2'b11, 1'b0, 4'd0, 4'd2, 1'b0);
        run("rr1", 2'b11, 1'b1, 4'd0, 4'd2, 1'b0);
        run("rr2", 2'b11, 1'b0, 4'd0, 4'd2, 1'b0);
        run("rr3", 2'b11, 1'b1, 4'd0, 4'd2, 1'b1);

        start0 = 4'd3; stop0 = 4'd7;
        run("single", 2'b01, 1'b0, 4'd3, 4'd7, 1'b1);

        start1 = 4'd14; stop1 = 4'd1;
        run("wrap", 2'b10, 1'b1, 4'd14, 4'd1, 1'b1);

        start0 = 4'd9; stop0 = 4'd9;
        run("zero", 2'b01, 1'b0, 4'd9, 4'd9, 1'b1);

        // Asynchronous reset in the middle of a run.
        start0 = 4'd2; stop0 = 4'd12;
        req = 2'b01;
        step();
        req = 2'b00;
        step();
        step();
        chk("mid.busy_pre", {7'd0, busy}, 8'd1);
        #2 reset = 1'b0;
        #1;
        chk_idle("mid_reset");
        chk("mid_reset.done_id", {7'd0, done_id}, 8'd0);
        step();
        #2 reset = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            chk_idle("mid_after");
        end

        // Counter stuck at 0 so stop 5 never matches.
        stuck  = 1'b1;
        start0 = 4'd3; stop0 = 4'd5;
        req = 2'b01;
        step();
        chk("stuck.grant", {6'd0, grant}, 8'd1);
        req = 2'b00;
`ifdef CSA_TIMEOUT_EN
        for (int j = 0; j < 17; j++) begin
            step();
            chk("to.busy", {7'd0, busy}, 8'd1);
            chk("to.err_early", {7'd0, err}, 8'd0);
            chk("to.done_early", {7'd0, done}, 8'd0);
        end
        step();
        chk("to.err", {7'd0, err}, 8'd1);
        chk("to.done", {7'd0, done}, 8'd0);
        chk("to.busy_idle", {7'd0, busy}, 8'd0);
        chk("to.done_id", {7'd0, done_id}, 8'd0);
        step();
        chk_idle("to_after");
`else
        for (int j = 0; j < 20; j++) begin
            step();
            chk("hang.busy", {7'd0, busy}, 8'd1);
            chk("hang.done", {7'd0, done}, 8'd0);
            chk("hang.err", {7'd0, err}, 8'd0);
        end
        reset = 1'b0;
        #1;
        chk_idle("hang_reset");
        reset = 1'b1;
`endif
        stuck = 1'b0;
        start1 = 4'd5; stop1 = 4'd6;
        step();
        run("final", 2'b10, 1'b1, 4'd5, 4'd6, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
